// File: rtl/jsilicon_alu_uart_core.sv
// Jsilicon compute-and-transmit core: latches two operands and an opcode, computes a
// double-width result in one cycle, then optionally sends it LSB byte first over 8N1 UART.
module jsilicon_alu_uart_core #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [2:0]          opcode,
  input  logic                tx_en,
  output logic [2*DATA_W-1:0] result,
  output logic                zero,
  output logic                carry,
  output logic                busy,
  output logic                done,
  output logic                tx
);
  // state    | meaning
  // IDLE     | waiting for start; operands latched on accept
  // EXEC     | result/zero/carry registered from the latched operands
  // TX_START | start bit (line low) for one bit period
  // TX_DATA  | eight data bits of the current byte, LSB first
  // TX_STOP  | stop bit (line high); then next byte or DONE
  // DONE     | one-cycle completion pulse, still busy
  localparam int RES_W  = 2 * DATA_W;
  localparam int SH_W   = $clog2(DATA_W);
  localparam int NBYTES = (RES_W + 7) / 8;
  localparam int PAD_W  = NBYTES * 8;
  localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LOAD = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);

  typedef enum logic [2:0] {IDLE, EXEC, TX_START, TX_DATA, TX_STOP, DONE} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]        op_q, op_d;
  logic              tx_en_q, tx_en_d;
  logic [RES_W-1:0]  result_q, result_d;
  logic              zero_q, zero_d, carry_q, carry_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [BYTE_W-1:0] byte_q, byte_d;
  logic              tx_q, tx_d;

  logic [RES_W-1:0]  alu_res;
  logic              alu_carry;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] diff;
  logic              lt;
  logic [PAD_W-1:0]  res_pad;
  logic [7:0]        cur_byte;

  // Narrow intermediates keep SUB wrapping at DATA_W before zero-extension.
  always_comb begin
    sum       = {1'b0, a_q} + {1'b0, b_q};
    diff      = a_q - b_q;
    lt        = (a_q < b_q);
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op_q)
      3'b000: begin alu_res = RES_W'(sum); alu_carry = sum[DATA_W]; end
      3'b001: begin alu_res = RES_W'(diff); alu_carry = lt; end
      3'b010: alu_res = RES_W'(a_q) * RES_W'(b_q);
      3'b011: alu_res = RES_W'(a_q & b_q);
      3'b100: alu_res = RES_W'(a_q | b_q);
      3'b101: alu_res = RES_W'(a_q ^ b_q);
      3'b110: alu_res = RES_W'(a_q) << b_q[SH_W-1:0];
      default: alu_res = RES_W'(lt);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    tx_en_d  = tx_en_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    tx_d     = 1'b1;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = opcode;
          tx_en_d = tx_en;
          state_d = EXEC;
        end
      end
      EXEC: begin
        result_d = alu_res;
        zero_d   = (alu_res == '0);
        carry_d  = alu_carry;
        byte_d   = '0;
        baud_d   = BAUD_LOAD;
        state_d  = tx_en_q ? TX_START : DONE;
      end
      TX_START: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_LOAD;
          bit_d   = '0;
          state_d = TX_DATA;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      TX_DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_LOAD;
          if (bit_q == 3'd7) state_d = TX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      TX_STOP: begin
        if (baud_q == '0) begin
          baud_d = BAUD_LOAD;
          if (byte_q == LAST_BYTE) begin
            state_d = DONE;
          end else begin
            byte_d  = byte_q + BYTE_W'(1);
            state_d = TX_START;
          end
        end else begin
          baud_d = baud_q - BAUD_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Line level is decoded from the next state so tx is a clean flop output.
    res_pad  = PAD_W'(result_q);
    cur_byte = 8'(res_pad >> {byte_d, 3'b000});
    case (state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = cur_byte[bit_d];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      tx_en_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      baud_q   <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      tx_en_q  <= tx_en_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      tx_q     <= tx_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign carry  = carry_q;
  assign busy   = (state_q != IDLE);
  assign done   = (state_q == DONE);
  assign tx     = tx_q;

endmodule

// File: tb/tb_jsilicon_alu_uart_core.sv
// Self-checking bench for jsilicon_alu_uart_core: vector table, random ops against an
// arithmetic reference, UART line stream checks, and reset/ignored-start corner cases.
module tb_jsilicon_alu_uart_core;
  localparam int DW    = 8;
  localparam int CPB   = 4;
  localparam int NB    = 2;
  localparam int FRAME = 10 * CPB;
  localparam int LINE  = NB * FRAME;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          start;
  logic [DW-1:0] a, b;
  logic [2:0]    opcode;
  logic          tx_en;
  logic [2*DW-1:0] result;
  logic          zero, carry, busy, done, tx;

  int checks = 0;
  int errors = 0;

  jsilicon_alu_uart_core #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .a(a), .b(b),
    .opcode(opcode), .tx_en(tx_en), .result(result), .zero(zero),
    .carry(carry), .busy(busy), .done(done), .tx(tx)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  va;
    logic [7:0]  vb;
    logic [15:0] res;
    logic        c;
    logic        z;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned operands.
  function automatic void model(input logic [2:0] op, input int ai, input int bi,
                                output logic [15:0] r, output logic c);
    int v;
    c = 1'b0;
    case (op)
      3'd0: begin v = ai + bi; c = (v > 255); end
      3'd1: begin v = (ai - bi + 256) % 256; c = (ai < bi); end
      3'd2: v = ai * bi;
      3'd3: v = ai & bi;
      3'd4: v = ai | bi;
      3'd5: v = ai ^ bi;
      3'd6: v = ai << (bi % DW);
      default: v = (ai < bi) ? 1 : 0;
    endcase
    r = v[15:0];
  endfunction

  // Expected line level for cycle c of the transmission (c = 0 is the first start-bit cycle).
  function automatic logic line_bit(input logic [15:0] r, input int c);
    int k, slot;
    k    = c / FRAME;
    slot = (c % FRAME) / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return logic'((int'(r) >> (8 * k + slot - 1)) & 1);
  endfunction

  task automatic run_compute(input logic [2:0] op, input logic [7:0] va, input logic [7:0] vb,
                             input logic [15:0] er, input logic ec, input logic ez);
    opcode = op; a = va; b = vb; tx_en = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    chk("exec_busy", busy, 1);
    chk("exec_done", done, 0);
    step();
    chk("done_pulse", done, 1);
    chk("result", result, er);
    chk("carry", carry, ec);
    chk("zero", zero, ez);
    chk("tx_idle_compute", tx, 1);
    step();
    chk("done_drop", done, 0);
    chk("busy_drop", busy, 0);
    chk("result_hold", result, er);
  endtask

  task automatic run_tx(input logic [2:0] op, input logic [7:0] va, input logic [7:0] vb,
                        input bit inject);
    logic [15:0] er;
    logic        ec;
    int          dones;
    model(op, int'(va), int'(vb), er, ec);
    opcode = op; a = va; b = vb; tx_en = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    chk("tx_exec_busy", busy, 1);
    chk("tx_exec_line", tx, 1);
    dones = 0;
    for (int c = 0; c < LINE; c++) begin
      if (inject && c == 30) begin
        start = 1'b1; a = 8'd1; b = 8'd1; opcode = 3'd0; tx_en = 1'b0;
      end
      if (inject && c == 32) start = 1'b0;
      step();
      chk("tx_line", tx, line_bit(er, c));
      if (done) dones++;
      if (c == 0) chk("tx_result", result, er);
    end
    chk("tx_no_early_done", dones, 0);
    step();
    chk("tx_done_pulse", done, 1);
    chk("tx_done_line", tx, 1);
    chk("tx_result_end", result, er);
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      if (done || busy) dones++;
    end
    chk("tx_quiet_after", dones, 0);
    chk("tx_result_after", result, er);
  endtask

  initial begin
    logic [15:0] er;
    logic        ec;
    int          dones;

    vecs[0] = '{3'd0, 8'd200, 8'd100, 16'h012C, 1'b1, 1'b0};
    vecs[1] = '{3'd1, 8'd3,   8'd5,   16'h00FE, 1'b1, 1'b0};
    vecs[2] = '{3'd7, 8'd3,   8'd5,   16'h0001, 1'b0, 1'b0};
    vecs[3] = '{3'd6, 8'h81,  8'd9,   16'h0102, 1'b0, 1'b0};
    vecs[4] = '{3'd5, 8'h5A,  8'h5A,  16'h0000, 1'b0, 1'b1};
    vecs[5] = '{3'd2, 8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0};
    vecs[6] = '{3'd3, 8'hF0,  8'h3C,  16'h0030, 1'b0, 1'b0};
    vecs[7] = '{3'd4, 8'hF0,  8'h0F,  16'h00FF, 1'b0, 1'b0};
    vecs[8] = '{3'd0, 8'd0,   8'd0,   16'h0000, 1'b0, 1'b1};
    vecs[9] = '{3'd1, 8'd5,   8'd3,   16'h0002, 1'b0, 1'b0};

    reset_n = 1'b0; start = 1'b1; a = 8'hFF; b = 8'hFF; opcode = 3'd2; tx_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
    end
    chk("rst_zero", zero, 0);
    chk("rst_carry", carry, 0);
    start = 1'b0;
    reset_n = 1'b1;
    step();
    chk("post_rst_no_accept", busy, 0);

    for (int i = 0; i < 10; i++)
      run_compute(vecs[i].op, vecs[i].va, vecs[i].vb, vecs[i].res, vecs[i].c, vecs[i].z);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      logic [7:0] va, vb;
      op = 3'($urandom_range(0, 7));
      va = 8'($urandom_range(0, 255));
      vb = 8'($urandom_range(0, 255));
      if (i % 8 == 0) vb = va;
      model(op, int'(va), int'(vb), er, ec);
      run_compute(op, va, vb, er, ec, er == 16'h0);
    end

    // MUL 15*17 = 0x00FF over the line, with an ignored start mid-frame.
    run_tx(3'd2, 8'd15, 8'd17, 1'b1);
    run_tx(3'd0, 8'd200, 8'd100, 1'b0);
    for (int i = 0; i < 3; i++)
      run_tx(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'b0);

    // Reset in the middle of TX_DATA aborts the frame with no done pulse.
    opcode = 3'd2; a = 8'd15; b = 8'd17; tx_en = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < CPB + 2 * CPB + 1; c++) step();
    chk("pre_abort_busy", busy, 1);
    reset_n = 1'b0;
    step();
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_result", result, 0);
    reset_n = 1'b1;
    dones = 0;
    for (int c = 0; c < LINE + 10; c++) begin
      step();
      if (done || busy || !tx) dones++;
    end
    chk("abort_quiet", dones, 0);
    run_compute(3'd0, 8'd7, 8'd9, 16'h0010, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
